// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, widths and fetch FSM states shared by the fetch stage and control unit.
package cpu_pkg;
    localparam int OPCODE_W = 6;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_JNZ  = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_CALL = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_RET  = 6'b001000;
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selector for sequential flow and J/JZ/JNZ.
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
) (
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               s_inc,
    input  logic               z,
    output logic [PC_W-1:0]    pc_nxt
);
    logic [OPCODE_W-1:0] op;
    logic                take;
    always_comb begin
        op     = instr[INSTR_W-1 -: OPCODE_W];
        take   = !s_inc && (op == OP_J || (op == OP_JZ && z) || (op == OP_JNZ && !z));
        pc_nxt = take ? instr[PC_W-1:0] : pc + PC_W'(1);
    end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage holding pc and zero flag, with ready-handshaked imem and halt.
// Define PC_FETCH_CALL_STACK_EN to add CALL/RET with a return stack and stack_ovf.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STACK_D  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               s_inc,
    input  logic               wez,
    input  logic               alu_zero,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic               z,
    output logic               halted
`ifdef PC_FETCH_CALL_STACK_EN
    ,
    output logic               stack_ovf
`endif
);
    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d, pc_nxt, pc_sel;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 z_q, z_d, instr_valid_q, instr_valid_d, halted_q, halted_d;

    pc_next #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_pc_next (
        .pc     (pc_q),
        .instr  (instr_q),
        .s_inc  (s_inc),
        .z      (z_q),
        .pc_nxt (pc_nxt)
    );

`ifdef PC_FETCH_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = STACK_D > 1 ? $clog2(STACK_D) : 1;
    logic [PC_W-1:0]     stack_q [STACK_D];
    logic [PC_W-1:0]     stack_d [STACK_D];
    logic [SP_W-1:0]     sp_q, sp_d, sp_m1;
    logic [IDX_W-1:0]    wr_idx;
    logic [OPCODE_W-1:0] op;
    logic                is_call, is_ret, full, empty, ovf_q, ovf_d;
    always_comb begin
        op      = instr_q[INSTR_W-1 -: OPCODE_W];
        is_call = state_q == EXEC && !s_inc && op == OP_CALL;
        is_ret  = state_q == EXEC && !s_inc && op == OP_RET;
        full    = sp_q == SP_W'(STACK_D);
        empty   = sp_q == '0;
        sp_m1   = sp_q - SP_W'(1);
        // a push into a full stack overwrites the top entry instead of growing
        wr_idx  = full ? IDX_W'(STACK_D - 1) : sp_q[IDX_W-1:0];
        stack_d = stack_q;
        if (is_call) stack_d[wr_idx] = pc_q + PC_W'(1);
        sp_d    = is_call ? (full ? sp_q : sp_q + SP_W'(1)) : is_ret ? (empty ? sp_q : sp_m1) : sp_q;
        ovf_d   = ovf_q | (is_call && full) | (is_ret && empty);
        pc_sel  = is_call ? instr_q[PC_W-1:0] :
                  is_ret  ? (empty ? RESET_PC : stack_q[sp_m1[IDX_W-1:0]]) : pc_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < STACK_D; i++) stack_q[i] <= '0;
        end else begin
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            stack_q <= stack_d;
        end
    end
    assign stack_ovf = ovf_q;
`else
    assign pc_sel = pc_nxt;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        z_d           = z_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        halted_d      = halted_q;
        if (state_q == FETCH && imem_ready) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = EXEC;
        end else if (state_q == EXEC) begin
            pc_d     = pc_sel;
            z_d      = wez ? alu_zero : z_q;
            state_d  = halt ? HALT : FETCH;
            halted_d = halt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            z_q           <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            z_q           <= z_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign z           = z_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
endmodule
